ptb_capture: RTL and testbench

PTB_CAPTURE -- requirements
Module: ptb_capture

---
 rtl/ptb_capture.sv | 185 ++++++++++++++++++
 tb/tb_ptb_capture.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ptb_capture.sv
// ptb_capture: turns a trigger into one event of N consecutive words read out of the
// pretrigger buffer, where N = max(pre_config, 3) + post_config + 1.
// Bit 0 of each written word marks the end of the event.
// Optional feature: define PTB_CAPTURE_DROP_CNT_EN to count triggers dropped for lack of
// downstream space; without it drop_cnt is tied to zero.
module ptb_capture #(
    parameter int unsigned P_DATA_WIDTH      = 22,
    parameter int unsigned P_PRE_CONF_WIDTH  = 5,
    parameter int unsigned P_POST_CONF_WIDTH = 12,
    parameter int unsigned P_LTC_WIDTH       = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ptb_rdy,
    input  logic [P_DATA_WIDTH-1:0]      ptb_in,
    input  logic                         trig,
    input  logic                         trig_en,
    input  logic [P_LTC_WIDTH-1:0]       ltc_in,
    input  logic [P_PRE_CONF_WIDTH-1:0]  pre_config,
    input  logic [P_POST_CONF_WIDTH-1:0] post_config,
    input  logic [15:0]                  fifo_space,
    output logic                         wr_en,
    output logic [P_DATA_WIDTH-1:0]      wr_data,
    output logic [P_LTC_WIDTH-1:0]       evt_ltc,
    output logic                         evt_ltc_valid,
    output logic                         busy,
    output logic [15:0]                  drop_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture
    } state_e;

    state_e                  state_q, state_d;
    logic                    wr_en_q, wr_en_d;
    logic [P_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [P_LTC_WIDTH-1:0]  evt_ltc_q, evt_ltc_d;
    logic                    evt_ltc_valid_q, evt_ltc_valid_d;
    logic                    busy_q, busy_d;
    logic [16:0]             cnt_q, cnt_d;      // words already issued in this event
    logic [16:0]             len_q, len_d;      // event length latched at acceptance
    logic                    trunc_q, trunc_d;  // event cut short by ptb_rdy falling

    logic [16:0] pre_eff;
    logic [16:0] evt_len;
    logic        space_ok;
    logic        drop_inc;
    logic        last_word;

    // The sample LSB is always replaced by the end-of-event marker.
    logic unused_ptb_lsb;
    assign unused_ptb_lsb = ptb_in[0];

    // Event length from the live configuration; 17 bits hold the worst case.
    always_comb begin
        pre_eff  = (17'(pre_config) < 17'd3) ? 17'd3 : 17'(pre_config);
        evt_len  = pre_eff + 17'(post_config) + 17'd1;
        space_ok = {1'b0, fifo_space} >= evt_len;
    end

    // Next-state logic for the capture FSM and all registered outputs.
    always_comb begin
        state_d         = state_q;
        wr_en_d         = 1'b0;
        wr_data_d       = wr_data_q;
        evt_ltc_d       = evt_ltc_q;
        evt_ltc_valid_d = 1'b0;
        busy_d          = 1'b0;
        cnt_d           = cnt_q;
        len_d           = len_q;
        trunc_d         = trunc_q;
        drop_inc        = 1'b0;
        last_word       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ptb_rdy && trig_en) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (!ptb_rdy || !trig_en) begin
                    state_d = StIdle;
                end else if (trig) begin
                    if (space_ok) begin
                        // Accept: first word goes out on the next cycle. N >= 4, so it
                        // can never be the last one.
                        state_d         = StCapture;
                        len_d           = evt_len;
                        cnt_d           = 17'd1;
                        trunc_d         = 1'b0;
                        wr_en_d         = 1'b1;
                        busy_d          = 1'b1;
                        wr_data_d       = {ptb_in[P_DATA_WIDTH-1:1], 1'b0};
                        evt_ltc_d       = ltc_in;
                        evt_ltc_valid_d = 1'b1;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end
            StCapture: begin
                // The marker bit of the word on the output tells us it was the last.
                if (wr_data_q[0]) begin
                    if (!trunc_q && ptb_rdy && trig_en) begin
                        state_d = StArmed;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d     = cnt_q + 17'd1;
                    last_word = (cnt_d == len_q) || !ptb_rdy;
                    trunc_d   = !ptb_rdy;
                    wr_en_d   = 1'b1;
                    busy_d    = 1'b1;
                    wr_data_d = {ptb_in[P_DATA_WIDTH-1:1], last_word};
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StIdle;
            wr_en_q         <= 1'b0;
            wr_data_q       <= '0;
            evt_ltc_q       <= '0;
            evt_ltc_valid_q <= 1'b0;
            busy_q          <= 1'b0;
            cnt_q           <= '0;
            len_q           <= '0;
            trunc_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            wr_en_q         <= wr_en_d;
            wr_data_q       <= wr_data_d;
            evt_ltc_q       <= evt_ltc_d;
            evt_ltc_valid_q <= evt_ltc_valid_d;
            busy_q          <= busy_d;
            cnt_q           <= cnt_d;
            len_q           <= len_d;
            trunc_q         <= trunc_d;
        end
    end

`ifdef PTB_CAPTURE_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of triggers refused for lack of downstream space.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`else
    logic unused_drop_inc;
    assign unused_drop_inc = drop_inc;
    assign drop_cnt        = '0;
`endif

    assign wr_en         = wr_en_q;
    assign wr_data       = wr_data_q;
    assign evt_ltc       = evt_ltc_q;
    assign evt_ltc_valid = evt_ltc_valid_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_ptb_capture.sv
// Scoreboard bench for ptb_capture: every accepted trigger pushes its expected words and
// time stamp; a negedge monitor pops and compares them as the DUT writes.
module tb_ptb_capture;

    localparam int unsigned DW = 22;
    localparam int unsigned LW = 48;
`ifdef PTB_CAPTURE_DROP_CNT_EN
    localparam bit DropEn = 1'b1;
`else
    localparam bit DropEn = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ptb_rdy = 1'b0;
    logic [DW-1:0] ptb_in = '0;
    logic          trig = 1'b0;
    logic          trig_en = 1'b0;
    logic [LW-1:0] ltc_in = '0;
    logic [4:0]    pre_config = '0;
    logic [11:0]   post_config = '0;
    logic [15:0]   fifo_space = '0;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic [LW-1:0] evt_ltc;
    logic          evt_ltc_valid;
    logic          busy;
    logic [15:0]   drop_cnt;

    ptb_capture dut (
        .clk          (clk),
        .rst          (rst),
        .ptb_rdy      (ptb_rdy),
        .ptb_in       (ptb_in),
        .trig         (trig),
        .trig_en      (trig_en),
        .ltc_in       (ltc_in),
        .pre_config   (pre_config),
        .post_config  (post_config),
        .fifo_space   (fifo_space),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .evt_ltc      (evt_ltc),
        .evt_ltc_valid(evt_ltc_valid),
        .busy         (busy),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_errors = 0;
    int            cyc = 0;
    logic [DW-1:0] exp_q[$];
    logic [LW-1:0] ltc_q[$];
    bit            in_evt = 1'b0;
    logic [15:0]   exp_drop = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pat(input int c);
        logic [31:0] v;
        v = 32'(c) * 32'h9E3779B1 + 32'h0135_7BDF;
        return v[DW-1:0];
    endfunction

    // One clock; inputs change 1 ns after the edge, ptb_in follows the cycle pattern.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ptb_in = pat(cyc);
        ltc_in = 48'h00A0_0000 + 48'(cyc);
    endtask

    // Pulse trig for one cycle; when acceptance is expected, push the expected words.
    task automatic fire(input int pre, input int post, input int space, input logic [LW-1:0] ltc,
                        input bit accept, input int trunc);
        int            n;
        logic [DW-1:0] w;
        n = ((pre < 3) ? 3 : pre) + post + 1;
        if (trunc > 0 && trunc < n) n = trunc;
        pre_config  = 5'(pre);
        post_config = 12'(post);
        fifo_space  = 16'(space);
        ltc_in      = ltc;
        trig        = 1'b1;
        if (accept) begin
            for (int i = 1; i <= n; i++) begin
                w    = pat(cyc + i - 1);
                w[0] = (i == n);
                exp_q.push_back(w);
            end
            ltc_q.push_back(ltc);
        end else if (ptb_rdy && trig_en && DropEn) begin
            exp_drop = exp_drop + 16'd1;
        end
        tick();
        trig = 1'b0;
    endtask

    task automatic drain(input int bound);
        int k = 0;
        while (exp_q.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        check_eq("drain_done", 64'(exp_q.size()), 64'd0);
        tick();
        tick();
        check_eq("ltc_all_seen", 64'(ltc_q.size()), 64'd0);
        check_eq("drop_cnt", 64'(drop_cnt), 64'(exp_drop));
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_wr_en", 64'(wr_en), 64'd0);
        check_eq("rst_wr_data", 64'(wr_data), 64'd0);
        check_eq("rst_evt_ltc", 64'(evt_ltc), 64'd0);
        check_eq("rst_evt_ltc_valid", 64'(evt_ltc_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    endtask

    // Monitor: compares every written word and time stamp against the scoreboard.
    always @(negedge clk) begin
        if (cyc > 0) begin
            check_eq("busy_vs_wr_en", 64'(busy), 64'(wr_en));
            if (wr_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_eq("wr_en_unexpected", 64'(wr_en), 64'd0);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    check_eq("wr_data", 64'(wr_data), 64'(e));
                    in_evt = !e[0];
                end
            end else if (in_evt) begin
                check_eq("wr_en_gap", 64'(wr_en), 64'd1);
                in_evt = 1'b0;
            end
            if (evt_ltc_valid === 1'b1) begin
                if (ltc_q.size() == 0) begin
                    check_eq("evt_ltc_valid_extra", 64'(evt_ltc_valid), 64'd0);
                end else begin
                    check_eq("evt_ltc", 64'(evt_ltc), 64'(ltc_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        check_reset_outputs();
        rst = 1'b0;
        ptb_rdy = 1'b1;
        trig_en = 1'b1;
        tick();
        tick();

        // Basic event: N = 8 + 20 + 1 = 29.
        fire(8, 20, 100, 48'h1234, 1'b1, 0);
        drain(60);

        // Pre-trigger clipped to 3: N = 4.
        fire(1, 0, 100, 48'h5555, 1'b1, 0);
        drain(20);

        // Not enough space: dropped, stays armed, then accepted at the exact boundary.
        fire(8, 20, 10, 48'h1, 1'b0, 0);
        tick();
        check_eq("drop_after_10", 64'(drop_cnt), 64'(exp_drop));
        fire(8, 20, 28, 48'h2, 1'b0, 0);
        tick();
        check_eq("drop_after_28", 64'(drop_cnt), 64'(exp_drop));
        fire(8, 20, 29, 48'hABCD, 1'b1, 0);
        drain(60);

        // Maximal configuration: N = 31 + 4095 + 1 = 4127.
        fire(31, 4095, 4126, 48'h3, 1'b0, 0);
        tick();
        fire(31, 4095, 4127, 48'hFEDC_BA98_7654, 1'b1, 0);
        drain(4300);

        // Second trigger mid-capture is ignored.
        fire(8, 20, 100, 48'h7777, 1'b1, 0);
        repeat (5) tick();
        fifo_space = 16'd100;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        drain(60);

        // Reset while word 10 is on the output.
        fire(8, 20, 100, 48'h9999, 1'b1, 0);
        repeat (9) tick();
        rst = 1'b1;
        tick();
        exp_q.delete();
        ltc_q.delete();
        in_evt = 1'b0;
        exp_drop = '0;
        check_reset_outputs();
        rst = 1'b0;
        tick();
        check_eq("post_rst_wr_en", 64'(wr_en), 64'd0);
        tick();

        // ptb_rdy falls so that word 10 carries the end marker, then IDLE.
        fire(8, 20, 100, 48'h4242, 1'b1, 10);
        repeat (8) tick();
        ptb_rdy = 1'b0;
        drain(40);
        fire(8, 20, 5, 48'h6, 1'b0, 0);
        tick();
        check_eq("idle_trig_ignored", 64'(drop_cnt), 64'(exp_drop));
        ptb_rdy = 1'b1;
        tick();
        tick();

        // trig_en falling mid-capture does not truncate; trig in IDLE is ignored.
        fire(8, 20, 100, 48'h8888, 1'b1, 0);
        repeat (3) tick();
        trig_en = 1'b0;
        drain(60);
        fire(8, 20, 5, 48'h7, 1'b0, 0);
        tick();
        check_eq("trig_en_low_ignored", 64'(drop_cnt), 64'(exp_drop));
        trig_en = 1'b1;
        tick();
        tick();

        // Drop once more after re-arming, then a normal event.
        fire(8, 20, 0, 48'h8, 1'b0, 0);
        tick();
        check_eq("drop_rearmed", 64'(drop_cnt), 64'(exp_drop));
        fire(3, 7, 11, 48'hC0FFEE, 1'b1, 0);
        drain(30);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
